// File: rtl/exp_share_pkg.sv
// exp_share_pkg: state encoding and IEEE-754 single constants shared by exp_share_arb and its arbiter.
package exp_share_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, HOLD = 2'd2} state_t;
  localparam logic [31:0] FP_ONE = 32'h3F80_0000;
  localparam logic [31:0] FP_PINF = 32'h7F80_0000;
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
  localparam int FP_EXP_LSB = 23;
  localparam int FP_EXP_MSB = 30;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; the search starts just after ptr_i and wraps modulo N_REQ.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]  idx_o
);
  int best;
  // Distance from ptr_i+1: the requester with the smallest distance wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    best = N_REQ;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_i[i] && ((i + 2 * N_REQ - 1 - int'(ptr_i)) % N_REQ) < best) begin
        best = (i + 2 * N_REQ - 1 - int'(ptr_i)) % N_REQ;
        gnt_o = '0;
        gnt_o[i] = 1'b1;
        idx_o = ID_W'(i);
      end
    end
  end
endmodule

// File: rtl/exp_share_arb.sv
// exp_share_arb: time-shares one combinational multi-cycle taylor_exp among N_REQ requesters (round-robin).
// Define EXP_SPECIAL_BYPASS_EN to answer +/-0, +/-Inf and NaN operands directly, skipping taylor_exp.
module exp_share_arb
  import exp_share_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int EXP_LAT = 2,
  parameter int ID_W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [32*N_REQ-1:0]  req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic [31:0]          exp_in,
  input  logic [31:0]          exp_out,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_data,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 busy
);
  localparam int CNT_W = EXP_LAT > 1 ? $clog2(EXP_LAT) : 1;
  state_t state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d, rsp_id_q, rsp_id_d, win;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] exp_in_q, exp_in_d, rsp_data_q, rsp_data_d, sel, special_res;
  logic rsp_valid_q, rsp_valid_d, special, accept;
  logic [N_REQ-1:0] gnt;

  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_rr (
    .req_i(req_valid),
    .ptr_i(ptr_q),
    .gnt_o(gnt),
    .idx_o(win)
  );

  assign accept = state_q == IDLE && |req_valid;
  assign req_ready = state_q == IDLE ? gnt : '0;

  always_comb begin
    sel = '0;
    for (int i = 0; i < N_REQ; i++) sel = gnt[i] ? req_data[32*i +: 32] : sel;
  end

`ifdef EXP_SPECIAL_BYPASS_EN
  // Any NaN returns the canonical quiet NaN; -Inf underflows to +0.
  assign special = &sel[FP_EXP_MSB:FP_EXP_LSB] || sel[30:0] == '0;
  assign special_res = sel[30:0] == '0 ? FP_ONE : |sel[FP_EXP_LSB-1:0] ? FP_QNAN : sel[31] ? FP_ZERO : FP_PINF;
`else
  assign special = 1'b0;
  assign special_res = FP_ZERO;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    exp_in_d = exp_in_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d = rsp_id_q;
    case (state_q)
      IDLE: if (accept) begin
        ptr_d = win;
        rsp_id_d = win;
        if (special) begin
          rsp_data_d = special_res;
          rsp_valid_d = 1'b1;
          state_d = HOLD;
        end else begin
          exp_in_d = sel;
          cnt_d = CNT_W'(EXP_LAT - 1);
          state_d = WAIT;
        end
      end
      WAIT: if (cnt_q == '0) begin
        rsp_data_d = exp_out;
        rsp_valid_d = 1'b1;
        state_d = HOLD;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
      HOLD: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q <= ID_W'(N_REQ - 1);
      cnt_q <= '0;
      exp_in_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q <= '0;
      rsp_id_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      exp_in_q <= exp_in_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q <= rsp_id_d;
    end
  end

  assign exp_in = exp_in_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data = rsp_data_q;
  assign rsp_id = rsp_id_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_exp_share_arb.sv
// tb_exp_share_arb: directed checks of exp_share_arb at EXP_LAT 2 (main), 1 and 4, sharing one stimulus.
// Each taylor_exp stand-in outputs 0xDEADBEEF until its operand has been stable long enough to settle.
module tb_exp_share_arb;
  logic clk = 0, rst_n = 0, rsp_ready = 0;
  logic [3:0] req_valid = '0;
  logic [127:0] req_data = '0;
  logic [3:0] req_ready, l1_req_ready, l4_req_ready;
  logic [31:0] exp_in, exp_out, rsp_data, l1_exp_in, l1_exp_out, l1_rsp_data, l4_exp_in, l4_exp_out, l4_rsp_data;
  logic rsp_valid, busy, l1_rsp_valid, l1_busy, l4_rsp_valid, l4_busy;
  logic [1:0] rsp_id, l1_rsp_id, l4_rsp_id;
  logic [31:0] last0 = 0, last1 = 0, last4 = 0;
  int age0 = 0, age1 = 0, age4 = 0;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  exp_share_arb #(.N_REQ(4), .EXP_LAT(2), .ID_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .exp_in(exp_in), .exp_out(exp_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy));
  exp_share_arb #(.N_REQ(4), .EXP_LAT(1), .ID_W(2)) dut_l1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data), .req_ready(l1_req_ready),
    .exp_in(l1_exp_in), .exp_out(l1_exp_out), .rsp_valid(l1_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(l1_rsp_data), .rsp_id(l1_rsp_id), .busy(l1_busy));
  exp_share_arb #(.N_REQ(4), .EXP_LAT(4), .ID_W(2)) dut_l4 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data), .req_ready(l4_req_ready),
    .exp_in(l4_exp_in), .exp_out(l4_exp_out), .rsp_valid(l4_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(l4_rsp_data), .rsp_id(l4_rsp_id), .busy(l4_busy));

  function automatic logic [31:0] fexp(input logic [31:0] x);
    return {x[15:0], x[31:16]} ^ 32'h3F80_0001;
  endfunction

  // An operand set at edge T is settled for the capture at edge T+LAT, and not one edge earlier.
  always @(negedge clk) begin
    if (exp_in !== last0) begin last0 = exp_in; age0 = 0; end else age0++;
    if (l1_exp_in !== last1) begin last1 = l1_exp_in; age1 = 0; end else age1++;
    if (l4_exp_in !== last4) begin last4 = l4_exp_in; age4 = 0; end else age4++;
    exp_out = age0 >= 1 ? fexp(exp_in) : 32'hDEAD_BEEF;
    l1_exp_out = age1 >= 0 ? fexp(l1_exp_in) : 32'hDEAD_BEEF;
    l4_exp_out = age4 >= 3 ? fexp(l4_exp_in) : 32'hDEAD_BEEF;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 0;
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_reset;
    tick();
    tick();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    tests++; if (rsp_data !== 32'h0) begin fails++; $display("FAIL reset_rsp_data got %h want 0", rsp_data); end
    tests++; if (rsp_id !== 2'd0) begin fails++; $display("FAIL reset_rsp_id got %0d want 0", rsp_id); end
    tests++; if (exp_in !== 32'h0) begin fails++; $display("FAIL reset_exp_in got %h want 0", exp_in); end
    tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_ready_idle got %b want 0000", req_ready); end
    req_valid = 4'b1111;
    #1;
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL reset_first_winner got %b want 0001", req_ready); end
    req_valid = 4'b0000;
    rst_n = 1;
    tick();
  endtask

  task automatic test_single;
    logic [31:0] op;
    int nbusy;
    op = 32'h3DCC_CCCD;
    req_data[31:0] = op;
    req_valid = 4'b0001;
    rsp_ready = 1;
    #1;
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL single_grant got %b want 0001", req_ready); end
    tick();
    req_valid = 4'b0000;
    nbusy = busy ? 1 : 0;
    tests++; if (exp_in !== op) begin fails++; $display("FAIL single_exp_in got %h want %h", exp_in, op); end
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL single_early_t0 got %b want 0", rsp_valid); end
    tick();
    nbusy += busy ? 1 : 0;
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL single_early_t1 got %b want 0", rsp_valid); end
    tick();
    nbusy += busy ? 1 : 0;
    tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL single_valid got %b want 1", rsp_valid); end
    tests++; if (rsp_data !== fexp(op)) begin fails++; $display("FAIL single_data got %h want %h", rsp_data, fexp(op)); end
    tests++; if (rsp_id !== 2'd0) begin fails++; $display("FAIL single_id got %0d want 0", rsp_id); end
    tick();
    nbusy += busy ? 1 : 0;
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL single_hold_one got %b want 0", rsp_valid); end
    tests++; if (nbusy != 3) begin fails++; $display("FAIL single_busy_cycles got %0d want 3", nbusy); end
  endtask

  task automatic test_contention(output logic [31:0] op1);
    logic [31:0] ops [4];
    logic [3:0] eg;
    logic [1:0] eid;
    ops = '{32'h3A83_126F, 32'h3C23_D70A, 32'h4120_0000, 32'h4000_0000};
    op1 = ops[1];
    do_reset();
    req_data = {ops[3], ops[2], ops[1], ops[0]};
    req_valid = 4'b1111;
    rsp_ready = 1;
    #1;
    for (int k = 0; k < 5; k++) begin
      eid = 2'(k % 4);
      eg = 4'b0001 << eid;
      tests++; if (req_ready !== eg) begin fails++; $display("FAIL contention_grant%0d got %b want %b", k, req_ready, eg); end
      tick();
      tick();
      tick();
      tests++; if (rsp_valid !== 1'b1 || rsp_id !== eid) begin fails++; $display("FAIL contention_id%0d got v=%b id=%0d want v=1 id=%0d", k, rsp_valid, rsp_id, eid); end
      tests++; if (rsp_data !== fexp(ops[eid])) begin fails++; $display("FAIL contention_data%0d got %h want %h", k, rsp_data, fexp(ops[eid])); end
      tick();
    end
  endtask

  task automatic test_backpressure(input logic [31:0] op1);
    rsp_ready = 0;
    #1;
    tests++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL bp_grant got %b want 0010", req_ready); end
    tick();
    tick();
    tick();
    tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== fexp(op1)) begin fails++; $display("FAIL bp_first got v=%b id=%0d d=%h want v=1 id=1 d=%h", rsp_valid, rsp_id, rsp_data, fexp(op1)); end
    for (int k = 0; k < 5; k++) begin
      tick();
      tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== fexp(op1)) begin fails++; $display("FAIL bp_stable%0d got v=%b id=%0d d=%h", k, rsp_valid, rsp_id, rsp_data); end
      tests++; if (req_ready !== 4'b0000 || exp_in !== op1) begin fails++; $display("FAIL bp_no_accept%0d got rdy=%b exp_in=%h want 0000 %h", k, req_ready, exp_in, op1); end
    end
    rsp_ready = 1;
    tick();
    tests++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL bp_release got v=%b busy=%b want 0 0", rsp_valid, busy); end
    tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL bp_next_grant got %b want 0100", req_ready); end
    req_valid = 4'b0000;
    tick();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL bp_idle got %b want 0", busy); end
  endtask

  task automatic test_reset_midop;
    req_data[31:0] = 32'hBFC3_D70A;
    req_valid = 4'b0001;
    #1;
    tick();
    req_valid = 4'b0000;
    tick();
    tests++; if (busy !== 1'b1 || exp_in !== 32'hBFC3_D70A) begin fails++; $display("FAIL midop_inflight got busy=%b exp_in=%h", busy, exp_in); end
    rst_n = 0;
    #1;
    tests++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin fails++; $display("FAIL midop_async got busy=%b v=%b want 0 0", busy, rsp_valid); end
    tests++; if (exp_in !== 32'h0 || rsp_data !== 32'h0 || rsp_id !== 2'd0) begin fails++; $display("FAIL midop_zero got %h %h %0d", exp_in, rsp_data, rsp_id); end
    tick();
    rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL midop_no_rsp%0d got %b want 0", k, rsp_valid); end
    end
    req_valid = 4'b1111;
    #1;
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL midop_next_grant got %b want 0001", req_ready); end
    req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_exp_lat;
    logic [31:0] op;
    op = 32'h3F06_A7F0;
    do_reset();
    req_data[31:0] = op;
    req_valid = 4'b0001;
    rsp_ready = 1;
    #1;
    tick();
    req_valid = 4'b0000;
    for (int k = 1; k <= 4; k++) begin
      tick();
      tests++; if (rsp_valid !== (k == 2)) begin fails++; $display("FAIL lat2_valid_t%0d got %b want %b", k, rsp_valid, k == 2); end
      tests++; if (l1_rsp_valid !== (k == 1)) begin fails++; $display("FAIL lat1_valid_t%0d got %b want %b", k, l1_rsp_valid, k == 1); end
      tests++; if (l4_rsp_valid !== (k == 4)) begin fails++; $display("FAIL lat4_valid_t%0d got %b want %b", k, l4_rsp_valid, k == 4); end
      tests++; if (l4_exp_in !== op || l1_exp_in !== op) begin fails++; $display("FAIL lat_exp_in_t%0d got %h %h want %h", k, l1_exp_in, l4_exp_in, op); end
      if (k == 1) begin tests++; if (l1_rsp_data !== fexp(op)) begin fails++; $display("FAIL lat1_data got %h want %h", l1_rsp_data, fexp(op)); end end
      if (k == 2) begin tests++; if (rsp_data !== fexp(op)) begin fails++; $display("FAIL lat2_data got %h want %h", rsp_data, fexp(op)); end end
      if (k == 4) begin tests++; if (l4_rsp_data !== fexp(op)) begin fails++; $display("FAIL lat4_data got %h want %h", l4_rsp_data, fexp(op)); end end
    end
    tick();
  endtask

  task automatic test_special;
    logic [31:0] ops [3];
    logic [31:0] res [3];
    ops = '{32'h0000_0000, 32'hFF80_0000, 32'h7FC0_0001};
    res = '{32'h3F80_0000, 32'h0000_0000, 32'h7FC0_0000};
    do_reset();
    rsp_ready = 1;
    for (int k = 0; k < 3; k++) begin
      req_data[31:0] = ops[k];
      req_valid = 4'b0001;
      #1;
      tick();
      req_valid = 4'b0000;
`ifdef EXP_SPECIAL_BYPASS_EN
      tests++; if (rsp_valid !== 1'b1 || rsp_data !== res[k]) begin fails++; $display("FAIL special%0d got v=%b d=%h want v=1 d=%h", k, rsp_valid, rsp_data, res[k]); end
      tests++; if (exp_in !== 32'h0) begin fails++; $display("FAIL special%0d_exp_in got %h want 0", k, exp_in); end
      tick();
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL special%0d_idle got %b want 0", k, busy); end
      repeat (4) tick();
`else
      tests++; if (rsp_valid !== 1'b0 || exp_in !== ops[k]) begin fails++; $display("FAIL special%0d_early got v=%b exp_in=%h want v=0 exp_in=%h (result %h only with bypass)", k, rsp_valid, exp_in, ops[k], res[k]); end
      tick();
      tick();
      tests++; if (rsp_valid !== 1'b1 || rsp_data !== fexp(ops[k])) begin fails++; $display("FAIL special%0d_lat got v=%b d=%h want v=1 d=%h", k, rsp_valid, rsp_data, fexp(ops[k])); end
      repeat (4) tick();
`endif
    end
  endtask

  initial begin
    logic [31:0] op1;
    test_reset();
    test_single();
    test_contention(op1);
    test_backpressure(op1);
    test_reset_midop();
    test_exp_lat();
    test_special();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
